// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU (1 or 2 stages) with valid/ready flow control, tag passthrough and optional ALU_FLAGS_EN status flags
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       Ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic [TAG_W-1:0] OutTag,
  output logic             Zero,
  output logic             Neg,
  output logic             Carry,
  output logic             Ovf
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRA = 3'd6, OP_SRL = 3'd7;

  logic             out_v_q;
  logic [WIDTH-1:0] out_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_rdy;
  logic             op_v;
  logic [2:0]       op_ctrl;
  logic [WIDTH-1:0] op_a, op_b, res_d;
  logic [TAG_W-1:0] op_tag;
  logic [SW-1:0]    sh;

  assign out_rdy = !out_v_q | OutReady;

  generate
    if (STAGES == 2) begin : g_s2
      logic             s1_v_q;
      logic [2:0]       s1_ctrl_q;
      logic [WIDTH-1:0] s1_a_q, s1_b_q;
      logic [TAG_W-1:0] s1_tag_q;
      // operand stage: captures the request whenever it has room downstream or is empty
      always_ff @(posedge Clk) begin
        if (Reset) begin
          s1_v_q    <= 1'b0;
          s1_ctrl_q <= '0;
          s1_a_q    <= '0;
          s1_b_q    <= '0;
          s1_tag_q  <= '0;
        end else if (InReady) begin
          s1_v_q <= InValid;
          if (InValid) begin
            s1_ctrl_q <= Ctrl;
            s1_a_q    <= A;
            s1_b_q    <= B;
            s1_tag_q  <= InTag;
          end
        end
      end
      assign InReady = !s1_v_q | out_rdy;
      assign op_v    = s1_v_q;
      assign op_ctrl = s1_ctrl_q;
      assign op_a    = s1_a_q;
      assign op_b    = s1_b_q;
      assign op_tag  = s1_tag_q;
    end else begin : g_s1
      assign InReady = out_rdy;
      assign op_v    = InValid;
      assign op_ctrl = Ctrl;
      assign op_a    = A;
      assign op_b    = B;
      assign op_tag  = InTag;
    end
  endgenerate

  assign sh = op_b[SW-1:0];

  // result mux; every code decodes, so no X can escape
  always_comb begin
    res_d = op_a + op_b;
    case (op_ctrl)
      OP_SUB:  res_d = op_a - op_b;
      OP_AND:  res_d = op_a & op_b;
      OP_OR:   res_d = op_a | op_b;
      OP_XOR:  res_d = op_a ^ op_b;
      OP_SLL:  res_d = op_a << sh;
      OP_SRA:  res_d = $signed(op_a) >>> sh;
      OP_SRL:  res_d = op_a >> sh;
      default: res_d = op_a + op_b;
    endcase
  end

  // result stage: holds while the consumer stalls, data only updates on a valid handoff
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_v_q   <= 1'b0;
      out_q     <= '0;
      out_tag_q <= '0;
    end else if (out_rdy) begin
      out_v_q <= op_v;
      if (op_v) begin
        out_q     <= res_d;
        out_tag_q <= op_tag;
      end
    end
  end

  assign OutValid = out_v_q;
  assign Out      = out_q;
  assign OutTag   = out_tag_q;

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_d, flags_q;
  logic       is_add, is_sub, carry_d, ovf_d;
  assign is_add  = op_ctrl == OP_ADD;
  assign is_sub  = op_ctrl == OP_SUB;
  assign carry_d = is_add ? (res_d < op_a) : is_sub ? (op_a < op_b) : 1'b0;
  assign ovf_d   = is_add ? (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res_d[WIDTH-1] != op_a[WIDTH-1]) :
                   is_sub ? (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res_d[WIDTH-1] != op_a[WIDTH-1]) : 1'b0;
  assign flags_d = {res_d == '0, res_d[WIDTH-1], carry_d, ovf_d};
  // flags travel with the result and share its stall behaviour
  always_ff @(posedge Clk) begin
    if (Reset) flags_q <= '0;
    else if (out_rdy && op_v) flags_q <= flags_d;
  end
  assign {Zero, Neg, Carry, Ovf} = flags_q;
`else
  assign {Zero, Neg, Carry, Ovf} = 4'b0000;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of a 32-bit 2-stage and an 8-bit 1-stage alu_pipe
module tb_alu_pipe;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRA = 3'd6, OP_SRL = 3'd7;
`ifdef ALU_FLAGS_EN
  localparam logic [3:0] FL = 4'hF;
`else
  localparam logic [3:0] FL = 4'h0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, or32 = 1'b1;
  logic [2:0]  c32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [3:0]  t32 = '0;
  logic        ir32, ov32, z32, n32, cy32, vf32;
  logic [31:0] o32;
  logic [3:0]  ot32;

  logic        iv8 = 1'b0, or8 = 1'b1;
  logic [2:0]  c8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  t8 = '0;
  logic        ir8, ov8, z8, n8, cy8, vf8;
  logic [7:0]  o8;
  logic [3:0]  ot8;

  int n_chk = 0;
  int n_fail = 0;

  alu_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut32 (
    .Clk(clk), .Reset(rst), .InValid(iv32), .InReady(ir32), .Ctrl(c32), .A(a32), .B(b32),
    .InTag(t32), .OutValid(ov32), .OutReady(or32), .Out(o32), .OutTag(ot32),
    .Zero(z32), .Neg(n32), .Carry(cy32), .Ovf(vf32));

  alu_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) dut8 (
    .Clk(clk), .Reset(rst), .InValid(iv8), .InReady(ir8), .Ctrl(c8), .A(a8), .B(b8),
    .InTag(t8), .OutValid(ov8), .OutReady(or8), .Out(o8), .OutTag(ot8),
    .Zero(z8), .Neg(n8), .Carry(cy8), .Ovf(vf8));

  task automatic send(input bit w8, input logic [2:0] c, input logic [31:0] a, b, input logic [3:0] t);
    bit done;
    done = 1'b0;
    if (w8) begin c8 = c; a8 = a[7:0]; b8 = b[7:0]; t8 = t; iv8 = 1'b1; end
    else begin c32 = c; a32 = a; b32 = b; t32 = t; iv32 = 1'b1; end
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      done = w8 ? ir8 : ir32;
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0;
    iv32 = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout w8=%0d tag=%0d: InReady never rose", w8, t);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (ov32 !== 1'b0 || o32 !== 32'h0 || ot32 !== 4'h0 || {z32, n32, cy32, vf32} !== 4'h0) begin
      n_fail++; $display("FAIL reset32 got v=%b out=%h tag=%h flags=%b want 0", ov32, o32, ot32, {z32, n32, cy32, vf32}); end
    n_chk++; if (ov8 !== 1'b0 || o8 !== 8'h0 || ot8 !== 4'h0) begin
      n_fail++; $display("FAIL reset8 got v=%b out=%h tag=%h want 0", ov8, o8, ot8); end
    rst = 1'b0;
    #1;
    n_chk++; if (ir32 !== 1'b1 || ir8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b%b want 11", ir32, ir8); end
  endtask

  task automatic test_ops32;
    logic [2:0]  vc [11];
    logic [31:0] va [11], vb [11], ve [11];
    logic [3:0]  vf [11];
    vc = '{OP_ADD, OP_SRA, OP_SRL, OP_SLL, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SRA};
    va = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h1, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0,
           32'hF0F0F0F0, 32'h7FFFFFFF, 32'h3, 32'h40000000};
    vb = '{32'h1, 32'h4, 32'h4, 32'd33, 32'h7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h1, 32'h3, 32'd36};
    ve = '{32'h0, 32'hF8000000, 32'h08000000, 32'h2, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0,
           32'h0FF00FF0, 32'h80000000, 32'h0, 32'h04000000};
    vf = '{4'b1010, 4'b0100, 4'b0000, 4'b0000, 4'b0110, 4'b0100, 4'b0100, 4'b0000, 4'b0101, 4'b1000, 4'b0000};
    or32 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(1'b0, vc[i], va[i], vb[i], 4'(i));
      n_chk++; if (ov32 !== 1'b0) begin
        n_fail++; $display("FAIL ops32_latency[%0d] OutValid got %b want 0 one cycle after accept", i, ov32); end
      @(posedge clk);
      #1;
      n_chk++; if (ov32 !== 1'b1 || o32 !== ve[i] || ot32 !== 4'(i) || {z32, n32, cy32, vf32} !== (vf[i] & FL)) begin
        n_fail++;
        $display("FAIL ops32[%0d] got v=%b out=%h tag=%h flags=%b want v=1 out=%h tag=%h flags=%b",
                 i, ov32, o32, ot32, {z32, n32, cy32, vf32}, ve[i], 4'(i), vf[i] & FL);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ops8;
    logic [2:0] vc [5];
    logic [7:0] va [5], vb [5], ve [5];
    logic [3:0] vf [5];
    vc = '{OP_SUB, OP_ADD, OP_SRA, OP_SLL, OP_SRL};
    va = '{8'h80, 8'h80, 8'h81, 8'h81, 8'h81};
    vb = '{8'h01, 8'h80, 8'd9, 8'd7, 8'd15};
    ve = '{8'h7F, 8'h00, 8'hC0, 8'h80, 8'h01};
    vf = '{4'b0001, 4'b1011, 4'b0100, 4'b0100, 4'b0000};
    or8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, vc[i], {24'h0, va[i]}, {24'h0, vb[i]}, 4'(i + 8));
      n_chk++; if (ov8 !== 1'b1 || o8 !== ve[i] || ot8 !== 4'(i + 8) || {z8, n8, cy8, vf8} !== (vf[i] & FL)) begin
        n_fail++;
        $display("FAIL ops8[%0d] got v=%b out=%h tag=%h flags=%b want v=1 out=%h tag=%h flags=%b",
                 i, ov8, o8, ot8, {z8, n8, cy8, vf8}, ve[i], 4'(i + 8), vf[i] & FL);
      end
    end
    @(posedge clk);
    #1;
    n_chk++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL ops8_drain OutValid got %b want 0", ov8); end
  endtask

  task automatic test_back_to_back;
    or32 = 1'b0;
    iv32 = 1'b1; c32 = OP_ADD; a32 = 32'd10; b32 = 32'd1; t32 = 4'd1;
    @(posedge clk); #1;
    a32 = 32'd20; b32 = 32'd2; t32 = 4'd2;
    @(posedge clk); #1;
    a32 = 32'd30; b32 = 32'd3; t32 = 4'd3;
    #1;
    n_chk++; if (ir32 !== 1'b0 || ov32 !== 1'b1 || o32 !== 32'd11 || ot32 !== 4'd1) begin
      n_fail++; $display("FAIL stall_full got rdy=%b v=%b out=%0d tag=%0d want rdy=0 v=1 out=11 tag=1", ir32, ov32, o32, ot32); end
    @(posedge clk); #1;
    n_chk++; if (ir32 !== 1'b0 || ov32 !== 1'b1 || o32 !== 32'd11 || ot32 !== 4'd1) begin
      n_fail++; $display("FAIL stall_hold got rdy=%b v=%b out=%0d tag=%0d want rdy=0 v=1 out=11 tag=1", ir32, ov32, o32, ot32); end
    or32 = 1'b1;
    #1;
    n_chk++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL stall_release InReady got %b want 1", ir32); end
    @(posedge clk); #1;
    iv32 = 1'b0;
    n_chk++; if (ov32 !== 1'b1 || o32 !== 32'd22 || ot32 !== 4'd2) begin
      n_fail++; $display("FAIL drain2 got v=%b out=%0d tag=%0d want v=1 out=22 tag=2", ov32, o32, ot32); end
    @(posedge clk); #1;
    n_chk++; if (ov32 !== 1'b1 || o32 !== 32'd33 || ot32 !== 4'd3) begin
      n_fail++; $display("FAIL drain3 got v=%b out=%0d tag=%0d want v=1 out=33 tag=3", ov32, o32, ot32); end
    @(posedge clk); #1;
    n_chk++; if (ov32 !== 1'b0) begin n_fail++; $display("FAIL drain_empty OutValid got %b want 0", ov32); end
  endtask

  task automatic test_stream;
    int got;
    bit started;
    got = 0;
    started = 1'b0;
    or32 = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      if (cyc < 16) begin iv32 = 1'b1; c32 = OP_ADD; a32 = 32'd100; b32 = 32'(cyc); t32 = 4'(cyc); end
      else iv32 = 1'b0;
      #1;
      if (cyc < 16) begin
        n_chk++; if (ir32 !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", cyc, ir32); end
      end
      @(posedge clk); #1;
      if (ov32 === 1'b1) begin
        n_chk++; if (ot32 !== 4'(got) || o32 !== 32'(100 + got)) begin
          n_fail++; $display("FAIL stream_out[%0d] got out=%0d tag=%0d want out=%0d tag=%0d", got, o32, ot32, 100 + got, got); end
        got++;
        started = 1'b1;
      end else if (started && got < 16) begin
        n_chk++; n_fail++;
        $display("FAIL stream_bubble at cycle %0d after %0d results, want OutValid=1", cyc, got);
      end
    end
    iv32 = 1'b0;
    n_chk++; if (got != 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", got); end
  endtask

  task automatic test_reset_flight;
    int extra;
    extra = 0;
    or32 = 1'b0;
    iv32 = 1'b1; c32 = OP_ADD; a32 = 32'd500; b32 = 32'd5; t32 = 4'd5;
    @(posedge clk); #1;
    t32 = 4'd6; b32 = 32'd6;
    @(posedge clk); #1;
    iv32 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (ov32 !== 1'b0 || o32 !== 32'h0 || ot32 !== 4'h0 || ir32 !== 1'b1) begin
      n_fail++; $display("FAIL flight_reset got v=%b out=%h tag=%h rdy=%b want v=0 out=0 tag=0 rdy=1", ov32, o32, ot32, ir32); end
    rst = 1'b0;
    or32 = 1'b1;
    send(1'b0, OP_ADD, 32'd40, 32'd2, 4'd9);
    @(posedge clk); #1;
    n_chk++; if (ov32 !== 1'b1 || o32 !== 32'd42 || ot32 !== 4'd9) begin
      n_fail++; $display("FAIL flight_new got v=%b out=%0d tag=%0d want v=1 out=42 tag=9", ov32, o32, ot32); end
    repeat (4) begin
      @(posedge clk); #1;
      if (ov32 === 1'b1) extra++;
    end
    n_chk++; if (extra != 0) begin n_fail++; $display("FAIL flight_ghost got %0d stray results want 0", extra); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops32();
    test_ops8();
    test_back_to_back();
    test_stream();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
